// File: rtl/cmos_cap_pkg.sv
// cmos_cap_pkg: shared types and constants for the CMOS capture window block
package cmos_cap_pkg;
  localparam int RGB_W = 16;
  localparam int FCNT_W = 8;
  typedef enum logic [1:0] {SETTLE, IDLE, ACTIVE, DISCARD} cap_state_t;
  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/cmos_capture_win_if.sv
// cmos_capture_win_if: sensor input and pixel output bundle of cmos_capture_win
interface cmos_capture_win_if;
  import cmos_cap_pkg::*;
  logic cap_en;
  logic cam_vsync;
  logic cam_href;
  logic [7:0] cam_data;
  logic pix_valid;
  logic [RGB_W-1:0] pix_data;
  logic frame_start;
  logic frame_done;
  logic [FCNT_W-1:0] frame_cnt;
  logic line_err;
  modport master (
    output cap_en, cam_vsync, cam_href, cam_data,
    input  pix_valid, pix_data, frame_start, frame_done, frame_cnt, line_err
  );
  modport slave (
    input  cap_en, cam_vsync, cam_href, cam_data,
    output pix_valid, pix_data, frame_start, frame_done, frame_cnt, line_err
  );
endinterface

// File: rtl/cmos_byte_pack.sv
// cmos_byte_pack: pairs sensor bytes (high byte first) within an href run, flags odd runs
module cmos_byte_pack
  import cmos_cap_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             href,
  input  logic [7:0]       data,
  output logic             pair_valid,
  output logic [RGB_W-1:0] pair_data,
  output logic             odd_err
);
  logic       phase;
  logic       href_d;
  logic [7:0] hi;
  // phase is forced to 0 whenever href is low, so every run starts on a high byte
  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= 1'b0;
      href_d <= 1'b0;
      hi     <= '0;
    end else begin
      href_d <= href;
      phase  <= href & ~phase;
      if (href & ~phase) hi <= data;
    end
  end
  assign pair_valid = href & phase;
  assign pair_data  = {hi, data};
  assign odd_err    = ~href & href_d & phase;
endmodule

// File: rtl/cmos_capture_win.sv
// cmos_capture_win: RGB565 sensor capture with settle frames, crop window and frame FSM.
// Define CMOS_CAPTURE_DECIM_EN for 2:1 decimation per axis inside the window.
module cmos_capture_win
  import cmos_cap_pkg::*;
#(
  parameter int H_PIXEL     = 640,
  parameter int V_PIXEL     = 480,
  parameter int WIN_X0      = 0,
  parameter int WIN_Y0      = 0,
  parameter int WIN_W       = 640,
  parameter int WIN_H       = 480,
  parameter int WAIT_FRAMES = 10,
  parameter int CNT_W       = 12
) (
  input logic               cam_pclk,
  input logic               cam_rst,
  cmos_capture_win_if.slave cif
);
  localparam int XS = min_i(WIN_X0, H_PIXEL);
  localparam int YS = min_i(WIN_Y0, V_PIXEL);
  localparam logic [CNT_W-1:0] X0 = CNT_W'(XS);
  localparam logic [CNT_W-1:0] Y0 = CNT_W'(YS);
  localparam logic [CNT_W-1:0] XW = CNT_W'(min_i(WIN_X0 + WIN_W, H_PIXEL) - XS);
  localparam logic [CNT_W-1:0] YH = CNT_W'(min_i(WIN_Y0 + WIN_H, V_PIXEL) - YS);
  localparam logic [CNT_W-1:0] VP = CNT_W'(V_PIXEL);
  localparam logic [CNT_W-1:0] WF = CNT_W'(WAIT_FRAMES - 1);
  cap_state_t       state, state_n;
  logic             r_vsync, vs_d, r_href, eh_d;
  logic [7:0]       r_data;
  logic [CNT_W-1:0] x_cnt, y_cnt, settle_cnt, dx, dy;
  logic             eh, vs_rise, vs_fall, first, keep, in_win, pv_n, fin;
  logic             pair_valid, odd_err;
  logic [RGB_W-1:0] pair_data;
  // lines that begin during vertical blanking never reach the pairing logic
  assign eh      = r_href & ~r_vsync;
  assign vs_rise = r_vsync & ~vs_d;
  assign vs_fall = ~r_vsync & vs_d;
  assign dx      = x_cnt - X0;
  assign dy      = y_cnt - Y0;
  assign in_win  = (dx < XW) && (dy < YH);
`ifdef CMOS_CAPTURE_DECIM_EN
  assign keep    = ~dx[0] & ~dy[0];
`else
  assign keep    = 1'b1;
`endif
  assign pv_n    = (state == ACTIVE) & pair_valid & in_win & keep;
  assign fin     = (state == ACTIVE) & vs_rise;
  cmos_byte_pack u_pack (
    .clk        (cam_pclk),
    .rst        (cam_rst),
    .href       (eh),
    .data       (r_data),
    .pair_valid (pair_valid),
    .pair_data  (pair_data),
    .odd_err    (odd_err)
  );
  always_ff @(posedge cam_pclk) begin
    if (cam_rst) state <= SETTLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      SETTLE:  state_n = (WAIT_FRAMES == 0 || (vs_rise && settle_cnt == WF)) ? IDLE : SETTLE;
      IDLE:    state_n = vs_fall ? (cif.cap_en ? ACTIVE : DISCARD) : IDLE;
      ACTIVE:  state_n = vs_rise ? IDLE : ACTIVE;
      DISCARD: state_n = vs_rise ? IDLE : DISCARD;
    endcase
  end
  // vsync pipeline resets high so a sensor already in blanking gives no false rise
  always_ff @(posedge cam_pclk) begin
    if (cam_rst) begin
      r_vsync         <= 1'b1;
      vs_d            <= 1'b1;
      r_href          <= 1'b0;
      eh_d            <= 1'b0;
      r_data          <= '0;
      settle_cnt      <= '0;
      x_cnt           <= '0;
      y_cnt           <= '0;
      first           <= 1'b0;
      cif.pix_valid   <= 1'b0;
      cif.pix_data    <= '0;
      cif.frame_start <= 1'b0;
      cif.frame_done  <= 1'b0;
      cif.frame_cnt   <= '0;
      cif.line_err    <= 1'b0;
    end else begin
      r_vsync         <= cif.cam_vsync;
      vs_d            <= r_vsync;
      r_href          <= cif.cam_href;
      eh_d            <= eh;
      r_data          <= cif.cam_data;
      settle_cnt      <= (state == SETTLE && vs_rise) ? settle_cnt + 1'b1 : settle_cnt;
      x_cnt           <= (vs_rise || !eh) ? '0 : (pair_valid && !(&x_cnt)) ? x_cnt + 1'b1 : x_cnt;
      y_cnt           <= vs_rise ? '0 : (eh_d && !eh && !(&y_cnt)) ? y_cnt + 1'b1 : y_cnt;
      first           <= (state == IDLE && vs_fall) ? 1'b1 : pv_n ? 1'b0 : first;
      cif.pix_valid   <= pv_n;
      cif.pix_data    <= pv_n ? pair_data : cif.pix_data;
      cif.frame_start <= pv_n & first;
      cif.frame_done  <= fin;
      cif.frame_cnt   <= fin ? cif.frame_cnt + 1'b1 : cif.frame_cnt;
      cif.line_err    <= cif.line_err | ((state == ACTIVE) & odd_err) | (fin & (y_cnt != VP));
    end
  end
endmodule

// File: tb/tb_cmos_capture_win.sv
// tb_cmos_capture_win: frame-table directed test of two window configurations
module tb_cmos_capture_win;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cap_en = 1'b0;
  logic vsync = 1'b1;
  logic href = 1'b0;
  logic [7:0] data = '0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int a_pix, b_pix, a_fs, fd_a, fd_b, a_last, pv_cyc, t_lat;
  logic raw = 1'b0;
  logic [7:0] ha, hb;
  logic [15:0] raw_data;
`ifdef CMOS_CAPTURE_DECIM_EN
  localparam int NA = 8, NB = 2, NODD = 8, NRST = 4, N3A = 8, N3B = 2;
`else
  localparam int NA = 32, NB = 6, NODD = 31, NRST = 8, N3A = 24, N3B = 6;
`endif
  typedef struct {
    bit cap; bit drop; int lines; int odd; bit rst_mid;
    int a_pix; int b_pix; int cnt; bit err; int done; int fs;
  } row_t;
  row_t rows[10];
  cmos_capture_win_if ia ();
  cmos_capture_win_if ib ();
  assign ia.cap_en = cap_en;
  assign ia.cam_vsync = vsync;
  assign ia.cam_href = href;
  assign ia.cam_data = data;
  assign ib.cap_en = cap_en;
  assign ib.cam_vsync = vsync;
  assign ib.cam_href = href;
  assign ib.cam_data = data;
  cmos_capture_win #(.H_PIXEL(8), .V_PIXEL(4), .WIN_X0(0), .WIN_Y0(0), .WIN_W(8), .WIN_H(4),
    .WAIT_FRAMES(2), .CNT_W(12)) dut_a (.cam_pclk(clk), .cam_rst(rst), .cif(ia));
  cmos_capture_win #(.H_PIXEL(8), .V_PIXEL(4), .WIN_X0(2), .WIN_Y0(1), .WIN_W(3), .WIN_H(2),
    .WAIT_FRAMES(2), .CNT_W(12)) dut_b (.cam_pclk(clk), .cam_rst(rst), .cif(ib));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_pix_valid"}, ia.pix_valid, 0);
    chk({tag, "_pix_data"}, ia.pix_data, 0);
    chk({tag, "_frame_start"}, ia.frame_start, 0);
    chk({tag, "_frame_done"}, ia.frame_done, 0);
    chk({tag, "_frame_cnt"}, ia.frame_cnt, 0);
    chk({tag, "_line_err"}, ia.line_err, 0);
  endtask
  task automatic send_frame(input row_t r);
    logic [7:0] hi;
    a_pix = 0; b_pix = 0; a_fs = 0; fd_a = 0; fd_b = 0; a_last = -1;
    cap_en = r.cap;
    tick(3);
    vsync = 1'b0;
    tick(3);
    for (int l = 0; l < r.lines; l++) begin
      if (r.drop && l == 1) cap_en = 1'b0;
      if (r.rst_mid && l == 1) begin
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        check_zero("mid_rst");
        rst = 1'b0;
        tick(1);
      end
      href = 1'b1;
      for (int b = 0; b < ((l == r.odd) ? 15 : 16); b++) begin
        hi = {4'(l), 4'(b / 2)};
        data = b[0] ? hi ^ 8'h5A : hi;
        tick(1);
      end
      href = 1'b0;
      data = '0;
      tick(4);
    end
    vsync = 1'b1;
    tick(6);
  endtask
  always @(negedge clk) begin
    if (ia.frame_start) begin
      chk("a_fs_with_valid", ia.pix_valid, 1);
      a_fs++;
    end
    if (ia.frame_done) fd_a++;
    if (ib.frame_done) fd_b++;
    if (ia.pix_valid && raw) begin
      pv_cyc = cyc;
      raw_data = ia.pix_data;
    end else if (ia.pix_valid) begin
      ha = ia.pix_data[15:8];
      chk("a_pair", ia.pix_data[7:0], ha ^ 8'h5A);
      chk("a_order", int'(ha) > a_last, 1);
`ifdef CMOS_CAPTURE_DECIM_EN
      chk("a_decim", ha[4] | ha[0], 0);
`endif
      if (ia.frame_start) begin
        chk("a_fs_pos", ha, 8'h00);
        chk("a_fs_first", a_pix, 0);
      end
      a_last = ha;
      a_pix++;
    end
    if (ib.pix_valid) begin
      hb = ib.pix_data[15:8];
      chk("b_pair", ib.pix_data[7:0], hb ^ 8'h5A);
      chk("b_win", (hb[3:0] >= 2 && hb[3:0] <= 4 && hb[7:4] >= 1 && hb[7:4] <= 2), 1);
`ifdef CMOS_CAPTURE_DECIM_EN
      chk("b_decim", (hb[3:0] == 2 || hb[3:0] == 4) && hb[7:4] == 1, 1);
`endif
      if (ib.frame_start) chk("b_fs_pos", hb, 8'h12);
      b_pix++;
    end
  end
  initial begin
    rows[0] = '{1, 0, 4, -1, 0, 0, 0, 0, 0, 0, 0};
    rows[1] = '{1, 0, 4, -1, 0, 0, 0, 0, 0, 0, 0};
    rows[2] = '{1, 0, 4, -1, 0, NA, NB, 1, 0, 1, 1};
    rows[3] = '{1, 0, 4, -1, 0, NA, NB, 2, 0, 1, 1};
    rows[4] = '{1, 1, 4, -1, 0, NA, NB, 3, 0, 1, 1};
    rows[5] = '{0, 0, 4, -1, 0, 0, 0, 3, 0, 0, 0};
    rows[6] = '{1, 0, 4, 2, 0, NODD, NB, 4, 1, 1, 1};
    rows[7] = '{1, 0, 4, -1, 1, NRST, 0, 0, 0, 0, 1};
    rows[8] = '{1, 0, 4, -1, 0, 0, 0, 0, 0, 0, 0};
    rows[9] = '{1, 0, 3, -1, 0, N3A, N3B, 1, 1, 1, 1};
    tick(3);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      send_frame(rows[i]);
      chk($sformatf("a_pix[%0d]", i), a_pix, rows[i].a_pix);
      chk($sformatf("b_pix[%0d]", i), b_pix, rows[i].b_pix);
      chk($sformatf("a_cnt[%0d]", i), ia.frame_cnt, rows[i].cnt);
      chk($sformatf("b_cnt[%0d]", i), ib.frame_cnt, rows[i].cnt);
      chk($sformatf("a_err[%0d]", i), ia.line_err, rows[i].err);
      chk($sformatf("b_err[%0d]", i), ib.line_err, rows[i].err);
      chk($sformatf("a_done[%0d]", i), fd_a, rows[i].done);
      chk($sformatf("b_done[%0d]", i), fd_b, rows[i].done);
      chk($sformatf("a_fs[%0d]", i), a_fs, rows[i].fs);
    end
    raw = 1'b1;
    pv_cyc = -100;
    cap_en = 1'b1;
    vsync = 1'b0;
    tick(3);
    href = 1'b1;
    data = 8'hF8;
    tick(1);
    data = 8'h1F;
    t_lat = cyc;
    tick(1);
    href = 1'b0;
    data = '0;
    tick(5);
    chk("latency", pv_cyc - t_lat, 2);
    chk("latency_data", raw_data, 16'hF81F);
    vsync = 1'b1;
    tick(6);
    raw = 1'b0;
    chk("latency_cnt", ia.frame_cnt, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
